// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline stages.
// Bus-controller state encoding, datapath widths and default bus timeout.
package mips_pkg;

    localparam int DATA_W      = 32;
    localparam int REG_W       = 5;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_t;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return |addr_lsb;
    endfunction

endpackage

// File: rtl/mem_bus_ctrl.sv
// Data-memory bus sequencer: holds one req/ack transaction and aborts it
// once the wait counter reaches its terminal count.
//
// state | meaning
// IDLE  | no access outstanding, ready for a start request
// BUS   | dm_req held, waiting for dm_ack or the timeout terminal count
module mem_bus_ctrl
    import mips_pkg::*;
#(
    parameter int W       = DATA_W,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         start_we,
    input  logic [W-1:0] start_addr,
    input  logic [W-1:0] start_wdata,
    input  logic         dm_ack,
    output logic         busy,
    output logic         done,
    output logic         timeout,
    output logic         dm_req,
    output logic         dm_we,
    output logic [W-1:0] dm_addr,
    output logic [W-1:0] dm_wdata
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] TC = CW'(TIMEOUT - 1);

    state_t        state;
    logic [CW-1:0] wait_cnt;

    // An ack in the terminal-count cycle completes the access instead of faulting.
    assign busy    = (state == BUS);
    assign done    = busy & dm_ack;
    assign timeout = busy & ~dm_ack & (wait_cnt == TC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_addr  <= '0;
            dm_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= BUS;
                        wait_cnt <= '0;
                        dm_req   <= 1'b1;
                        dm_we    <= start_we;
                        dm_addr  <= start_addr;
                        dm_wdata <= start_wdata;
                    end
                end
                BUS: begin
                    if (dm_ack || wait_cnt == TC) begin
                        state  <= IDLE;
                        dm_req <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    dm_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS memory stage: EX/MEM capture, branch resolution, load/store over the
// req/ack bus, and single-cycle retire pulses towards writeback.
module mem_access_stage #(
    parameter int DATA_W  = mips_pkg::DATA_W,
    parameter int REG_W   = mips_pkg::REG_W,
    parameter int TIMEOUT = mips_pkg::TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] MX2,
    input  logic [DATA_W-1:0] StoreData,
    input  logic              Zero,
    input  logic              Branch,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              RegWrite,
    input  logic [REG_W-1:0]  WriteReg,
    output logic              dm_req,
    output logic              dm_we,
    output logic [DATA_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_rdata,
    input  logic              dm_ack,
    output logic              wb_valid,
    output logic              wb_RegWrite,
    output logic [REG_W-1:0]  wb_WriteReg,
    output logic [DATA_W-1:0] wb_data,
    output logic              pc_src,
    output logic [DATA_W-1:0] pc_target,
    output logic              fault
);

    import mips_pkg::*;

    logic accept, mem_op, bad_op, start;
    logic busy, bus_done, bus_tmo;

    logic              cap_load;
    logic              cap_regwrite;
    logic [REG_W-1:0]  cap_writereg;
    logic              cap_taken;
    logic [DATA_W-1:0] cap_target;

    assign ex_ready = ~busy;
    assign accept   = ex_valid & ex_ready;
    assign mem_op   = MemRead | MemWrite;
    assign bad_op   = mem_op & (is_misaligned(ALUResult[1:0]) | (MemRead & MemWrite));
    assign start    = accept & mem_op & ~bad_op;

    mem_bus_ctrl #(
        .W       (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) u_bus (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .start_we    (MemWrite),
        .start_addr  (ALUResult),
        .start_wdata (StoreData),
        .dm_ack      (dm_ack),
        .busy        (busy),
        .done        (bus_done),
        .timeout     (bus_tmo),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_load     <= 1'b0;
            cap_regwrite <= 1'b0;
            cap_writereg <= '0;
            cap_taken    <= 1'b0;
            cap_target   <= '0;
            wb_valid     <= 1'b0;
            wb_RegWrite  <= 1'b0;
            wb_WriteReg  <= '0;
            wb_data      <= '0;
            pc_src       <= 1'b0;
            pc_target    <= '0;
            fault        <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            pc_src   <= 1'b0;
            fault    <= 1'b0;

            if (accept && !start) begin
                // Non-memory ops and rejected memory ops retire immediately.
                wb_valid    <= 1'b1;
                fault       <= bad_op;
                wb_RegWrite <= RegWrite & ~bad_op;
                wb_WriteReg <= WriteReg;
                wb_data     <= ALUResult;
                pc_src      <= Branch & Zero;
                pc_target   <= MX2;
            end else if (start) begin
                cap_load     <= MemRead;
                cap_regwrite <= RegWrite;
                cap_writereg <= WriteReg;
                cap_taken    <= Branch & Zero;
                cap_target   <= MX2;
            end

            if (bus_done) begin
                wb_valid    <= 1'b1;
                wb_RegWrite <= cap_regwrite & cap_load;
                wb_WriteReg <= cap_writereg;
                wb_data     <= cap_load ? dm_rdata : dm_addr;
                pc_src      <= cap_taken;
                pc_target   <= cap_target;
            end else if (bus_tmo) begin
                wb_valid    <= 1'b1;
                fault       <= 1'b1;
                wb_RegWrite <= 1'b0;
                wb_WriteReg <= cap_writereg;
                pc_src      <= cap_taken;
                pc_target   <= cap_target;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized and directed checks of mem_access_stage against an
// instruction-level reference model (retire record + expected bus activity).
module tb_mem_access_stage;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ALUResult, MX2, StoreData;
    logic        Zero, Branch, MemRead, MemWrite, RegWrite;
    logic [4:0]  WriteReg;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        dm_ack;
    logic        wb_valid, wb_RegWrite;
    logic [4:0]  wb_WriteReg;
    logic [31:0] wb_data;
    logic        pc_src;
    logic [31:0] pc_target;
    logic        fault;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.DATA_W(32), .REG_W(5), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ALUResult(ALUResult), .MX2(MX2), .StoreData(StoreData), .Zero(Zero),
        .Branch(Branch), .MemRead(MemRead), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .WriteReg(WriteReg),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite), .wb_WriteReg(wb_WriteReg),
        .wb_data(wb_data), .pc_src(pc_src), .pc_target(pc_target), .fault(fault)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic junk_inputs();
        ALUResult = $urandom;
        MX2       = $urandom;
        StoreData = $urandom;
        Zero      = 1'($urandom);
        Branch    = 1'($urandom);
        MemRead   = 1'($urandom);
        MemWrite  = 1'($urandom);
        RegWrite  = 1'($urandom);
        WriteReg  = 5'($urandom);
    endtask

    // lat = BUS cycle (1-based) in which ack is given; lat > TMO means never.
    task automatic run_op(input logic [31:0] alu, input logic [31:0] mx2,
                          input logic [31:0] sd, input logic zero, input logic br,
                          input logic mr, input logic mw, input logic rw,
                          input logic [4:0] wr, input int lat,
                          input logic [31:0] rdata);
        logic is_mem, is_bad, taken;
        int   reqs;
        is_mem = mr | mw;
        is_bad = is_mem && ((alu[1:0] != 2'b00) || (mr && mw));
        taken  = br & zero;

        ex_valid  = 1'b1;
        ALUResult = alu; MX2 = mx2; StoreData = sd; Zero = zero; Branch = br;
        MemRead = mr; MemWrite = mw; RegWrite = rw; WriteReg = wr;
        dm_ack    = 1'($urandom);
        dm_rdata  = $urandom;
        chk("ex_ready_accept", 32'(ex_ready), 32'd1);
        step();
        ex_valid = 1'b0;
        dm_ack   = 1'b0;
        junk_inputs();

        if (!is_mem || is_bad) begin
            chk("imm_wb_valid", 32'(wb_valid), 32'd1);
            chk("imm_fault", 32'(fault), 32'(is_bad));
            chk("imm_regwrite", 32'(wb_RegWrite), 32'(rw & ~is_bad));
            chk("imm_writereg", 32'(wb_WriteReg), 32'(wr));
            chk("imm_dm_req", 32'(dm_req), 32'd0);
            if (!is_bad) begin
                chk("imm_wb_data", wb_data, alu);
                chk("imm_pc_src", 32'(pc_src), 32'(taken));
                if (taken) chk("imm_pc_target", pc_target, mx2);
            end
            return;
        end

        reqs = 0;
        for (int c = 1; c <= TMO; c++) begin
            chk("bus_dm_req", 32'(dm_req), 32'd1);
            chk("bus_dm_we", 32'(dm_we), 32'(mw));
            chk("bus_dm_addr", dm_addr, alu);
            if (mw) chk("bus_dm_wdata", dm_wdata, sd);
            chk("bus_ex_ready", 32'(ex_ready), 32'd0);
            chk("bus_wb_valid", 32'(wb_valid), 32'd0);
            if (dm_req) reqs++;
            if (c == lat) begin
                dm_ack   = 1'b1;
                dm_rdata = rdata;
            end
            step();
            dm_ack   = 1'b0;
            dm_rdata = $urandom;
            if (c == lat) break;
        end

        chk("req_cycles", 32'(reqs), 32'((lat <= TMO) ? lat : TMO));
        chk("end_dm_req", 32'(dm_req), 32'd0);
        chk("end_ex_ready", 32'(ex_ready), 32'd1);
        chk("end_wb_valid", 32'(wb_valid), 32'd1);
        if (lat <= TMO) begin
            chk("ack_fault", 32'(fault), 32'd0);
            chk("ack_regwrite", 32'(wb_RegWrite), 32'(mr & rw));
            chk("ack_writereg", 32'(wb_WriteReg), 32'(wr));
            chk("ack_wb_data", wb_data, mr ? rdata : alu);
            chk("ack_pc_src", 32'(pc_src), 32'(taken));
            if (taken) chk("ack_pc_target", pc_target, mx2);
        end else begin
            chk("tmo_fault", 32'(fault), 32'd1);
            chk("tmo_regwrite", 32'(wb_RegWrite), 32'd0);
        end
    endtask

    task automatic idle_cycle();
        ex_valid = 1'b0;
        junk_inputs();
        dm_ack = 1'($urandom);
        step();
        dm_ack = 1'b0;
        chk("idle_wb_valid", 32'(wb_valid), 32'd0);
        chk("idle_pc_src", 32'(pc_src), 32'd0);
        chk("idle_fault", 32'(fault), 32'd0);
        chk("idle_dm_req", 32'(dm_req), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int kind, lat;
        logic mr, mw, br;

        rst = 1'b1; ex_valid = 1'b0; dm_ack = 1'b0; dm_rdata = '0;
        junk_inputs();
        repeat (3) step();
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_dm_req", 32'(dm_req), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_pc_src", 32'(pc_src), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_dm_addr", dm_addr, 32'd0);
        rst = 1'b0;
        step();

        run_op(32'h0000_0177, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 0, 32'h0);
        idle_cycle();
        run_op(32'h0000_0010, 32'h0000_002C, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 0, 32'h0);
        idle_cycle();
        run_op(32'h0000_0011, 32'h0000_002C, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 0, 32'h0);
        run_op(32'h0000_0100, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd9, 3, 32'h2D75_0177);
        run_op(32'h0000_0104, 32'h0, 32'h54B3_D4C3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd10, 2, 32'h0);
        run_op(32'h0000_0102, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd11, 1, 32'h0);
        run_op(32'h0000_0200, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd12, 0, 32'h0);
        run_op(32'h0000_0108, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd13, TMO + 1, 32'h0);
        run_op(32'h0000_010C, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd14, TMO, 32'hCAFE_F00D);
        run_op(32'h0000_0110, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd15, 1, 32'h1234_5678);

        // Reset in the middle of a bus access, with a simultaneous ack.
        ex_valid = 1'b1; ALUResult = 32'h0000_0120; MemRead = 1'b1; MemWrite = 1'b0;
        Branch = 1'b0; RegWrite = 1'b1; WriteReg = 5'd3;
        step();
        ex_valid = 1'b0;
        chk("rstbus_dm_req_before", 32'(dm_req), 32'd1);
        step();
        rst = 1'b1; dm_ack = 1'b1; dm_rdata = 32'hDEAD_BEEF;
        step();
        chk("rstbus_dm_req", 32'(dm_req), 32'd0);
        chk("rstbus_wb_valid", 32'(wb_valid), 32'd0);
        rst = 1'b0; dm_ack = 1'b0;
        step();
        chk("rstbus_wb_valid_after", 32'(wb_valid), 32'd0);
        chk("rstbus_ex_ready", 32'(ex_ready), 32'd1);

        for (int n = 0; n < 200; n++) begin
            kind = $urandom_range(0, 3);
            lat  = $urandom_range(1, TMO + 2);
            a    = $urandom;
            br   = 1'($urandom);
            mr   = 1'b0;
            mw   = 1'b0;
            case (kind)
                1: begin mr = 1'b1; a[1:0] = 2'b00; end
                2: begin mw = 1'b1; a[1:0] = 2'b00; end
                3: begin
                    br = 1'b0;
                    if ($urandom_range(0, 1) == 0) begin
                        mr = 1'($urandom); mw = ~mr;
                        a[1:0] = 2'($urandom_range(1, 3));
                    end else begin
                        mr = 1'b1; mw = 1'b1;
                    end
                end
                default: ;
            endcase
            run_op(a, $urandom, $urandom, 1'($urandom), br, mr, mw, 1'($urandom),
                   5'($urandom), lat, $urandom);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
